// File: rtl/wb_macro_pkg.sv
// Shared types and constants for the Wishbone user-macro controller.
// Holds the FSM states, address decode nibbles, CSR offsets and fixed response data.
package wb_macro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MACRO = 2'd1,
        CSR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned IDX_W = 4;

    localparam logic [3:0] BASE_NIBBLE = 4'h3;
    localparam logic [3:0] CSR_INDEX   = 4'hF;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_TIMEOUT = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] ERROR_DATA   = 32'h0000_0000;

endpackage

// File: rtl/wb_macro_csr.sv
// Control/status register file: macro soft resets, enables, ack timeout limit,
// sticky timeout status and the registered timeout interrupt.
module wb_macro_csr
    import wb_macro_pkg::*;
#(
    parameter int unsigned NUM_MACROS = 11,
    parameter int unsigned TO_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [1:0]            offset,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata_c,
    input  logic                  to_set,
    input  logic [IDX_W-1:0]      to_idx_in,
    output logic [NUM_MACROS-1:0] srst,
    output logic [NUM_MACROS-1:0] enable,
    output logic [TO_W-1:0]       timeout,
    output logic                  irq
);

    logic             irq_en;
    logic             to_flag;
    logic [IDX_W-1:0] to_idx;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en  <= 1'b0;
            srst    <= '0;
            enable  <= '1;
            timeout <= '1;
            to_flag <= 1'b0;
            to_idx  <= '0;
            irq     <= 1'b0;
        end else begin
            irq <= irq_en & to_flag;
            if (wr) begin
                case (offset)
                    REG_CTRL: begin
                        irq_en <= wdata[31];
                        srst   <= wdata[NUM_MACROS-1:0];
                    end
                    REG_ENABLE:  enable  <= wdata[NUM_MACROS-1:0];
                    REG_TIMEOUT: timeout <= wdata[TO_W-1:0];
                    default: ;
                endcase
            end
            // A fresh timeout outranks a simultaneous write-1-to-clear.
            if (to_set) begin
                to_flag <= 1'b1;
                to_idx  <= to_idx_in;
            end else if (wr && offset == REG_STATUS && wdata[31]) begin
                to_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        case (offset)
            REG_CTRL: begin
                rdata_c     = 32'(srst);
                rdata_c[31] = irq_en;
            end
            REG_ENABLE:  rdata_c = 32'(enable);
            REG_TIMEOUT: rdata_c = 32'(timeout);
            default: begin
                rdata_c[31]        = to_flag;
                rdata_c[IDX_W-1:0] = to_idx;
            end
        endcase
    end

endmodule

// File: rtl/wb_macro_ctrl.sv
// Wishbone slave that fans a 0x3X00_0000 window out to up to 15 user macros,
// with per-macro enable/soft-reset, ack timeout and a CSR block at index 0xF.
module wb_macro_ctrl
    import wb_macro_pkg::*;
#(
    parameter int unsigned NUM_MACROS = 11,
    parameter int unsigned TO_W       = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_MACROS-1:0]    m_wbs_stb_o,
    output logic [NUM_MACROS-1:0]    m_wb_rst_o,
    input  logic [NUM_MACROS-1:0]    m_wbs_ack_i,
    input  logic [32*NUM_MACROS-1:0] m_wbs_dat_i,
    output logic                     irq_o
);

    state_t                state, state_next;
    logic [IDX_W-1:0]      idx_q, idx_next;
    logic [TO_W-1:0]       timer_q, timer_next;
    logic [31:0]           dat_next;
    logic                  csr_wr, to_set;
    logic [31:0]           csr_rdata;
    logic [NUM_MACROS-1:0] srst, enable, stb_onehot;
    logic [TO_W-1:0]       timeout;
    logic                  sel_ack, hit, macro_ok, expire;
    logic [31:0]           sel_dat;
    logic [IDX_W-1:0]      req_idx;
    logic [15:0]           enable16, srst16;
    logic                  unused_adr;

    assign unused_adr = ^wbs_adr_i;
    assign hit        = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:28] == BASE_NIBBLE);
    assign req_idx    = wbs_adr_i[27:24];
    assign enable16   = 16'(enable);
    assign srst16     = 16'(srst);
    assign macro_ok   = (32'(req_idx) < NUM_MACROS) && enable16[req_idx] && !srst16[req_idx];
    assign expire     = (timeout != '0) && (timer_q == timeout - TO_W'(1));

    // Select the latched macro's ack, data and strobe position.
    always_comb begin
        sel_ack    = 1'b0;
        sel_dat    = '0;
        stb_onehot = '0;
        for (int unsigned k = 0; k < NUM_MACROS; k++) begin
            if (idx_q == 4'(k)) begin
                sel_ack       = m_wbs_ack_i[k];
                sel_dat       = m_wbs_dat_i[32*k +: 32];
                stb_onehot[k] = 1'b1;
            end
        end
    end

    assign m_wbs_stb_o = (state == MACRO && wbs_stb_i) ? stb_onehot : '0;
    assign m_wb_rst_o  = {NUM_MACROS{wb_rst_i}} | srst;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        timer_next = timer_q;
        dat_next   = wbs_dat_o;
        csr_wr     = 1'b0;
        to_set     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (req_idx == CSR_INDEX) begin
                        state_next = CSR;
                    end else if (macro_ok) begin
                        state_next = MACRO;
                        idx_next   = req_idx;
                        timer_next = '0;
                    end else begin
                        state_next = DONE;
                        dat_next   = ERROR_DATA;
                    end
                end
            end
            MACRO: begin
                // Abort beats ack, ack beats timeout.
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    state_next = DONE;
                    dat_next   = sel_dat;
                end else if (expire) begin
                    state_next = DONE;
                    dat_next   = TIMEOUT_DATA;
                    to_set     = 1'b1;
                end else begin
                    timer_next = timer_q + TO_W'(1);
                end
            end
            CSR: begin
                csr_wr     = wbs_we_i;
                state_next = DONE;
                if (!wbs_we_i) dat_next = csr_rdata;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q     <= '0;
            timer_q   <= '0;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
        end else begin
            idx_q     <= idx_next;
            timer_q   <= timer_next;
            wbs_dat_o <= dat_next;
            wbs_ack_o <= (state_next == DONE);
        end
    end

    wb_macro_csr #(
        .NUM_MACROS (NUM_MACROS),
        .TO_W       (TO_W)
    ) u_csr (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .wr        (csr_wr),
        .offset    (wbs_adr_i[3:2]),
        .wdata     (wbs_dat_i),
        .rdata_c   (csr_rdata),
        .to_set    (to_set),
        .to_idx_in (idx_q),
        .srst      (srst),
        .enable    (enable),
        .timeout   (timeout),
        .irq       (irq_o)
    );

endmodule

// File: tb/tb_wb_macro_ctrl.sv
// Directed bench for wb_macro_ctrl: macro reads, timeout, disabled/reset macros,
// ack-vs-timeout priority, master abort and reset mid-transaction.
module tb_wb_macro_ctrl;

    localparam int unsigned N = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we;
    logic [31:0]     adr, wdat;
    logic            ack_o;
    logic [31:0]     dat_o;
    logic [N-1:0]    stb_o, mrst_o, m_ack;
    logic [32*N-1:0] m_dat;
    logic            irq;

    int checks   = 0;
    int failures = 0;

    int          lat;
    logic [31:0] rd;
    logic [N-1:0] seen;

    always #5 clk = ~clk;

    wb_macro_ctrl #(.NUM_MACROS(N), .TO_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack_o),
        .wbs_dat_o   (dat_o),
        .m_wbs_stb_o (stb_o),
        .m_wb_rst_o  (mrst_o),
        .m_wbs_ack_i (m_ack),
        .m_wbs_dat_i (m_dat),
        .irq_o       (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transfer; lat = cycles from request to ack (0 if none within bound).
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output int l, output logic [31:0] r, output logic [N-1:0] s);
        l = 0;
        r = '0;
        s = '0;
        step();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        for (int i = 1; i <= 20; i++) begin
            step();
            s |= stb_o;
            if (ack_o) begin
                l = i;
                r = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; wdat = '0; m_ack = '0; m_dat = '0;
        step(); step();
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_stb", 32'(stb_o), 32'h0);
        chk("rst_mrst", 32'(mrst_o), 32'h7FF);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        step();
        chk("run_mrst", 32'(mrst_o), 32'h0);

        // Macro 2 read, ack 3 cycles after strobe.
        m_dat[32*2 +: 32] = 32'h1234_5678;
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3200_0000;
        step();
        chk("m2_stb", 32'(stb_o), 32'h004);
        step(); step(); step();
        m_ack[2] = 1'b1;
        chk("m2_noack_yet", 32'(ack_o), 32'h0);
        chk("m2_stb_pend", 32'(stb_o), 32'h004);
        step();
        chk("m2_ack", 32'(ack_o), 32'h1);
        chk("m2_dat", dat_o, 32'h1234_5678);
        chk("m2_stb_done", 32'(stb_o), 32'h0);
        m_ack[2] = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        chk("m2_ack_single", 32'(ack_o), 32'h0);

        // Timeout on macro 5 with TIMEOUT=4 and irq enabled.
        bus(32'h3F00_0008, 1'b1, 32'h0000_0004, lat, rd, seen);
        chk("wr_to_lat", 32'(lat), 32'd2);
        bus(32'h3F00_0000, 1'b1, 32'h8000_0000, lat, rd, seen);
        bus(32'h3F00_0008, 1'b0, 32'h0, lat, rd, seen);
        chk("rd_to", rd, 32'h0000_0004);
        bus(32'h3500_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("to_lat", 32'(lat), 32'd5);
        chk("to_dat", rd, 32'hDEAD_BEEF);
        chk("to_stb", 32'(seen), 32'h020);
        chk("to_irq", 32'(irq), 32'h1);
        bus(32'h3F00_000C, 1'b0, 32'h0, lat, rd, seen);
        chk("to_status", rd, 32'h8000_0005);
        bus(32'h3F00_000C, 1'b1, 32'h8000_0000, lat, rd, seen);
        chk("w1c_irq", 32'(irq), 32'h0);
        bus(32'h3F00_000C, 1'b0, 32'h0, lat, rd, seen);
        chk("w1c_status", rd, 32'h0000_0005);

        // Disabled macro 2 and unmapped index give a zero error ack.
        bus(32'h3F00_0004, 1'b1, 32'h0000_07FB, lat, rd, seen);
        bus(32'h3F00_0004, 1'b0, 32'h0, lat, rd, seen);
        chk("en_rd", rd, 32'h0000_07FB);
        bus(32'h3200_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("dis_lat", 32'(lat), 32'd1);
        chk("dis_dat", rd, 32'h0);
        chk("dis_stb", 32'(seen), 32'h0);
        bus(32'h3C00_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("unmap_lat", 32'(lat), 32'd1);
        chk("unmap_dat", rd, 32'h0);
        chk("unmap_stb", 32'(seen), 32'h0);
        bus(32'h3F00_0004, 1'b1, 32'h0000_07FF, lat, rd, seen);

        // Soft reset of macro 0 (irq_en cleared by this write).
        bus(32'h3F00_0000, 1'b1, 32'h0000_0001, lat, rd, seen);
        chk("srst_mrst", 32'(mrst_o), 32'h001);
        bus(32'h3F00_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("ctrl_rd", rd, 32'h0000_0001);
        bus(32'h3000_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("srst_lat", 32'(lat), 32'd1);
        chk("srst_dat", rd, 32'h0);
        chk("srst_stb", 32'(seen), 32'h0);
        bus(32'h3F00_0000, 1'b1, 32'h0, lat, rd, seen);
        chk("srst_clr", 32'(mrst_o), 32'h000);

        // Macro 3 acks on the very cycle the timeout would fire.
        m_dat[32*3 +: 32] = 32'hCAFE_F00D;
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0000;
        step(); step(); step(); step();
        chk("race_noack", 32'(ack_o), 32'h0);
        m_ack[3] = 1'b1;
        step();
        chk("race_ack", 32'(ack_o), 32'h1);
        chk("race_dat", dat_o, 32'hCAFE_F00D);
        m_ack[3] = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
        bus(32'h3F00_000C, 1'b0, 32'h0, lat, rd, seen);
        chk("race_status", rd, 32'h0000_0005);

        // Master abort mid-MACRO.
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0000;
        step();
        chk("abort_stb_on", 32'(stb_o), 32'h008);
        cyc = 1'b0; stb = 1'b0;
        step();
        chk("abort_stb_off", 32'(stb_o), 32'h0);
        chk("abort_ack0", 32'(ack_o), 32'h0);
        step(); step();
        chk("abort_ack1", 32'(ack_o), 32'h0);

        // Reset in the middle of a macro access with non-default CSRs.
        bus(32'h3F00_0008, 1'b1, 32'h0000_0010, lat, rd, seen);
        bus(32'h3F00_0004, 1'b1, 32'h0000_00FF, lat, rd, seen);
        bus(32'h3F00_0000, 1'b1, 32'h8000_0000, lat, rd, seen);
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000;
        step();
        chk("mid_stb", 32'(stb_o), 32'h002);
        step();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_stb", 32'(stb_o), 32'h0);
        chk("mid_rst_ack", 32'(ack_o), 32'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_mrst", 32'(mrst_o), 32'h7FF);
        cyc = 1'b0; stb = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("post_ack0", 32'(ack_o), 32'h0);
        step(); step();
        chk("post_ack1", 32'(ack_o), 32'h0);
        chk("post_mrst", 32'(mrst_o), 32'h0);
        bus(32'h3F00_0004, 1'b0, 32'h0, lat, rd, seen);
        chk("post_enable", rd, 32'h0000_07FF);
        bus(32'h3F00_0008, 1'b0, 32'h0, lat, rd, seen);
        chk("post_timeout", rd, 32'h0000_00FF);
        bus(32'h3F00_0000, 1'b0, 32'h0, lat, rd, seen);
        chk("post_ctrl", rd, 32'h0);
        bus(32'h3F00_000C, 1'b0, 32'h0, lat, rd, seen);
        chk("post_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
